// File: rtl/phase_pwm.sv
// Phase-shifted 50% square-wave drive for an ultrasonic transducer array.
// A shared period counter drives every channel; per-channel phase banks swap only at period boundaries.
`timescale 1ns/1ps
module phase_pwm #(
    parameter int CLK_FREQ     = 10_240_000,
    parameter int OUT_FREQ     = 40_000,
    parameter int NUM_CHANNELS = 2,
    parameter int MASTER       = 1,
    localparam int PERIOD      = CLK_FREQ / OUT_FREQ,
    localparam int PHASE_W     = $clog2(PERIOD)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CHANNELS-1:0][PHASE_W-1:0]  phases,
    input  logic                                  phases_valid,
    input  logic                                  enable,
    input  logic                                  sync_in,
    output logic                                  sync_out,
    output logic [NUM_CHANNELS-1:0]               trans,
    output logic                                  period_start
);

    if (PERIOD < 2 || (PERIOD & (PERIOD - 1)) != 0) begin : g_bad_period
        $error("phase_pwm: CLK_FREQ/OUT_FREQ must be a power of two >= 2");
    end
    if (NUM_CHANNELS < 1) begin : g_bad_channels
        $error("phase_pwm: NUM_CHANNELS must be at least 1");
    end

    // High for the first half-period after the channel's phase offset, modulo PERIOD.
    function automatic logic half_high(input logic [PHASE_W-1:0] c, input logic [PHASE_W-1:0] p);
        logic [PHASE_W-1:0] d;
        d = c - p;
        return ~d[PHASE_W-1];
    endfunction

    logic [PHASE_W-1:0]                     cnt;
    logic [NUM_CHANNELS-1:0][PHASE_W-1:0]   active;
    logic [NUM_CHANNELS-1:0][PHASE_W-1:0]   pending;
    logic                                   pend;
    logic                                   sync_p0, sync_p1, sync_p2;
    logic                                   sync_fwd;
    logic                                   sync_rise;
    logic                                   boundary;
    logic [NUM_CHANNELS-1:0]                trans_next;

    assign sync_rise = (MASTER == 0) && sync_p1 && !sync_p2;
    assign boundary  = enable && (cnt == '1);
    assign sync_out  = (MASTER != 0) ? period_start : sync_fwd;

    // Stage 0: two-flop synchronizer plus one extra flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= sync_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || sync_rise) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A strobe landing on the boundary bypasses the pending bank entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= '0;
            pending <= '0;
            pend    <= 1'b0;
        end else begin
            if (phases_valid) begin
                pending <= phases;
            end
            if (boundary && phases_valid) begin
                active <= phases;
                pend   <= 1'b0;
            end else if (boundary && pend) begin
                active <= pending;
                pend   <= 1'b0;
            end else if (phases_valid) begin
                pend <= 1'b1;
            end
        end
    end

    always_comb begin
        trans_next = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            trans_next[i] = half_high(cnt, active[i]);
        end
    end

    // Stage 1: registered outputs, one cycle behind the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans        <= '0;
            period_start <= 1'b0;
            sync_fwd     <= 1'b0;
        end else begin
            trans        <= enable ? trans_next : '0;
            period_start <= enable && (cnt == '0);
            sync_fwd     <= enable && sync_p1;
        end
    end

endmodule

// File: tb/tb_phase_pwm.sv
// Directed bench for phase_pwm: one MASTER=1 and one MASTER=0 instance at default timing.
`timescale 1ns/1ps
module tb_phase_pwm;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0][7:0] phases_m = '0, phases_s = '0;
    logic            valid_m = 1'b0, valid_s = 1'b0;
    logic            enable_m = 1'b0, enable_s = 1'b0;
    logic            sync_in_m = 1'b0, sync_in_s = 1'b0;
    logic            sync_out_m, sync_out_s, pstart_m, pstart_s;
    logic [1:0]      trans_m, trans_s;

    int   checks = 0, errors = 0;
    int   km = 0, ks = 0;
    int   em0 = 0, em1 = 0, es0 = 0, es1 = 0;
    logic exp_sync_s = 1'b0;

    always #5 clk = ~clk;

    phase_pwm #(.MASTER(1)) u_m (
        .clk(clk), .rst(rst), .phases(phases_m), .phases_valid(valid_m), .enable(enable_m),
        .sync_in(sync_in_m), .sync_out(sync_out_m), .trans(trans_m), .period_start(pstart_m)
    );

    phase_pwm #(.MASTER(0)) u_s (
        .clk(clk), .rst(rst), .phases(phases_s), .phases_valid(valid_s), .enable(enable_s),
        .sync_in(sync_in_s), .sync_out(sync_out_s), .trans(trans_s), .period_start(pstart_s)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_tr(input int c, input int p0, input int p1);
        logic [1:0] r;
        r[0] = ((c - p0 + 256) % 256) < 128;
        r[1] = ((c - p1 + 256) % 256) < 128;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        km++;
        ks++;
    endtask

    task automatic check_m();
        int c;
        c = (km - 1) % 256;
        chk_eq("m_trans", 32'(trans_m), 32'(exp_tr(c, em0, em1)));
        chk_eq("m_pstart", 32'(pstart_m), 32'(c == 0));
        chk_eq("m_sync_out", 32'(sync_out_m), 32'(c == 0));
    endtask

    task automatic check_s();
        int c;
        c = (ks - 1) % 256;
        chk_eq("s_trans", 32'(trans_s), 32'(exp_tr(c, es0, es1)));
        chk_eq("s_pstart", 32'(pstart_s), 32'(c == 0));
        chk_eq("s_sync_out", 32'(sync_out_s), 32'(exp_sync_s));
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_m_trans"}, 32'(trans_m), 32'd0);
        chk_eq({tag, "_m_pstart"}, 32'(pstart_m), 32'd0);
        chk_eq({tag, "_m_sync"}, 32'(sync_out_m), 32'd0);
        chk_eq({tag, "_s_trans"}, 32'(trans_s), 32'd0);
        chk_eq({tag, "_s_pstart"}, 32'(pstart_s), 32'd0);
        chk_eq({tag, "_s_sync"}, 32'(sync_out_s), 32'd0);
    endtask

    task automatic run_m_to(input int target);
        while (km < target) begin
            tick();
            check_m();
        end
    endtask

    task automatic run_s_to(input int target);
        while (ks < target) begin
            tick();
            check_s();
        end
    endtask

    task automatic pulse_m(input int p0, input int p1);
        phases_m[0] = 8'(p0);
        phases_m[1] = 8'(p1);
        valid_m = 1'b1;
        tick();
        check_m();
        valid_m = 1'b0;
    endtask

    task automatic pulse_s(input int p0, input int p1);
        phases_s[0] = 8'(p0);
        phases_s[1] = 8'(p1);
        valid_s = 1'b1;
        tick();
        check_s();
        valid_s = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Master: default phases, then deferred, overwritten and boundary-coincident updates
        enable_m = 1'b1;
        km = 0;
        run_m_to(266);
        pulse_m(0, 64);
        run_m_to(512);
        em0 = 0; em1 = 64;
        run_m_to(532);
        pulse_m(32, 32);
        run_m_to(552);
        pulse_m(200, 5);
        run_m_to(700);
        sync_in_m = 1'b1;
        run_m_to(704);
        sync_in_m = 1'b0;
        run_m_to(768);
        em0 = 200; em1 = 5;
        run_m_to(868);
        pulse_m(7, 7);
        run_m_to(1023);
        pulse_m(128, 0);
        em0 = 128; em1 = 0;
        run_m_to(1536);

        // Disabled: outputs forced low, strobe still captured as pending
        enable_m = 1'b0;
        repeat (3) begin
            tick();
            check_zero("disabled");
        end
        phases_m[0] = 8'd100;
        phases_m[1] = 8'd60;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        check_zero("disabled_strobe");
        enable_m = 1'b1;
        km = 0;
        run_m_to(256);
        em0 = 100; em1 = 60;
        run_m_to(356);
        pulse_m(3, 3);
        run_m_to(407);
        chk_eq("pre_rst_trans", 32'(trans_m), 32'd3);

        // Asynchronous reset mid-cycle with an update pending
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        km = 0;
        em0 = 0; em1 = 0;
        run_m_to(768);
        enable_m = 1'b0;

        // Slave: forced reload from sync_in does not swap banks
        phases_s[0] = 8'd30;
        phases_s[1] = 8'd0;
        valid_s = 1'b1;
        tick();
        valid_s = 1'b0;
        enable_s = 1'b1;
        ks = 0;
        run_s_to(256);
        es0 = 30; es1 = 0;
        run_s_to(306);
        pulse_s(90, 90);
        run_s_to(356);
        sync_in_s = 1'b1;
        tick();
        check_s();
        sync_in_s = 1'b0;
        tick();
        check_s();
        exp_sync_s = 1'b1;
        tick();
        check_s();
        exp_sync_s = 1'b0;
        ks = 0;
        run_s_to(256);
        es0 = 90; es1 = 90;
        run_s_to(512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
